alarm_clock: RTL and testbench



---
 rtl/alarm_clock.sv | 124 ++++++++++++
 tb/tb_alarm_clock.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// alarm_clock: 12-hour time-of-day clock with one programmable alarm.
// The time advances by one second on every Clock_1Sec edge. Alarm is high while
// the alarm is enabled and the current hour, minute and AM/PM equal the alarm setting.
module alarm_clock (
    input  logic       Clock_1Sec,
    input  logic       Reset,
    input  logic       LoadTime,
    input  logic       LoadAlm,
    input  logic       AlarmEnable,
    input  logic       Set_AM_PM,
    input  logic       Alarm_AM_PM_In,
    input  logic [5:0] SetSecs,
    input  logic [5:0] SetMins,
    input  logic [5:0] AlarmMinsIn,
    input  logic [3:0] SetHours,
    input  logic [3:0] AlarmHoursIn,
    output logic       AM_PM,
    output logic       Alarm,
    output logic [5:0] Secs_C,
    output logic [5:0] Mins_C,
    output logic [3:0] Hours_C
);

    logic [5:0] r_secs;
    logic [5:0] r_mins;
    logic [3:0] r_hours;
    logic       r_am_pm;

    logic [5:0] r_alm_mins;
    logic [3:0] r_alm_hours;
    logic       r_alm_am_pm;

    logic [5:0] w_secs_nxt;
    logic [5:0] w_mins_nxt;
    logic [3:0] w_hours_nxt;
    logic       w_am_pm_nxt;
    logic       w_min_carry;
    logic       w_hour_carry;

    // Increment logic: seconds carry into minutes, minutes into hours, all on one edge.
    // Range checks use >= so that out-of-range loaded values still wrap.
    always_comb begin
        w_secs_nxt   = r_secs;
        w_mins_nxt   = r_mins;
        w_hours_nxt  = r_hours;
        w_am_pm_nxt  = r_am_pm;
        w_min_carry  = 1'b0;
        w_hour_carry = 1'b0;

        if (r_secs >= 6'd59) begin
            w_secs_nxt  = '0;
            w_min_carry = 1'b1;
        end else begin
            w_secs_nxt = r_secs + 6'd1;
        end

        if (w_min_carry) begin
            if (r_mins >= 6'd59) begin
                w_mins_nxt   = '0;
                w_hour_carry = 1'b1;
            end else begin
                w_mins_nxt = r_mins + 6'd1;
            end
        end

        if (w_hour_carry) begin
            if (r_hours == 4'd11) begin
                w_hours_nxt = 4'd12;
                w_am_pm_nxt = ~r_am_pm;
            end else if (r_hours >= 4'd12) begin
                w_hours_nxt = 4'd1;
            end else begin
                w_hours_nxt = r_hours + 4'd1;
            end
        end
    end

    // Time register: a load takes priority over counting and suppresses the increment.
    always_ff @(posedge Clock_1Sec or posedge Reset) begin
        if (Reset) begin
            r_secs  <= '0;
            r_mins  <= '0;
            r_hours <= 4'd12;
            r_am_pm <= 1'b0;
        end else if (LoadTime) begin
            r_secs  <= SetSecs;
            r_mins  <= SetMins;
            r_hours <= SetHours;
            r_am_pm <= Set_AM_PM;
        end else begin
            r_secs  <= w_secs_nxt;
            r_mins  <= w_mins_nxt;
            r_hours <= w_hours_nxt;
            r_am_pm <= w_am_pm_nxt;
        end
    end

    // Alarm setting register, loaded independently of the time register.
    always_ff @(posedge Clock_1Sec or posedge Reset) begin
        if (Reset) begin
            r_alm_mins  <= '0;
            r_alm_hours <= 4'd12;
            r_alm_am_pm <= 1'b0;
        end else if (LoadAlm) begin
            r_alm_mins  <= AlarmMinsIn;
            r_alm_hours <= AlarmHoursIn;
            r_alm_am_pm <= Alarm_AM_PM_In;
        end
    end

    // Alarm compare ignores seconds, so it stays high for the whole matching minute.
    always_comb begin
        Alarm = AlarmEnable
              && (r_hours == r_alm_hours)
              && (r_mins  == r_alm_mins)
              && (r_am_pm == r_alm_am_pm);
    end

    assign Secs_C  = r_secs;
    assign Mins_C  = r_mins;
    assign Hours_C = r_hours;
    assign AM_PM   = r_am_pm;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed self-checking bench for alarm_clock.
module tb_alarm_clock;

    logic       clk;
    logic       rst;
    logic       load_time;
    logic       load_alm;
    logic       alarm_en;
    logic       set_ampm;
    logic       alm_ampm_in;
    logic [5:0] set_secs;
    logic [5:0] set_mins;
    logic [5:0] alm_mins_in;
    logic [3:0] set_hours;
    logic [3:0] alm_hours_in;
    logic       am_pm;
    logic       alarm;
    logic [5:0] secs;
    logic [5:0] mins;
    logic [3:0] hours;

    int unsigned n_assert;
    int unsigned n_fail;

    alarm_clock dut (
        .Clock_1Sec     (clk),
        .Reset          (rst),
        .LoadTime       (load_time),
        .LoadAlm        (load_alm),
        .AlarmEnable    (alarm_en),
        .Set_AM_PM      (set_ampm),
        .Alarm_AM_PM_In (alm_ampm_in),
        .SetSecs        (set_secs),
        .SetMins        (set_mins),
        .AlarmMinsIn    (alm_mins_in),
        .SetHours       (set_hours),
        .AlarmHoursIn   (alm_hours_in),
        .AM_PM          (am_pm),
        .Alarm          (alarm),
        .Secs_C         (secs),
        .Mins_C         (mins),
        .Hours_C        (hours)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int ap);
        check({tag, ".hours"}, int'(hours), h);
        check({tag, ".mins"},  int'(mins),  m);
        check({tag, ".secs"},  int'(secs),  s);
        check({tag, ".ampm"},  int'(am_pm), ap);
    endtask

    task automatic set_time(input int h, input int m, input int s, input int ap);
        set_hours = 4'(h);
        set_mins  = 6'(m);
        set_secs  = 6'(s);
        set_ampm  = ap[0];
    endtask

    task automatic set_alarm(input int h, input int m, input int ap);
        alm_hours_in = 4'(h);
        alm_mins_in  = 6'(m);
        alm_ampm_in  = ap[0];
    endtask

    // Load a time on one edge, then release the load.
    task automatic load_time_now(input int h, input int m, input int s, input int ap);
        set_time(h, m, s, ap);
        load_time = 1'b1;
        tick();
        load_time = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset with both loads held high: loads must be ignored.
        rst       = 1'b1;
        load_time = 1'b1;
        load_alm  = 1'b1;
        alarm_en  = 1'b0;
        set_time(5, 10, 20, 1);
        set_alarm(3, 4, 1);
        repeat (3) tick();
        check_time("reset", 12, 0, 0, 0);
        check("reset.alarm", int'(alarm), 0);
        // Alarm registers reset to 12:00 AM, matching the reset time.
        alarm_en = 1'b1;
        #1;
        check("reset.alarm_regs", int'(alarm), 1);
        alarm_en  = 1'b0;
        #1;
        check("reset.alarm_dis", int'(alarm), 0);
        load_time = 1'b0;
        load_alm  = 1'b0;
        rst       = 1'b0;

        // Noon rollover.
        load_time_now(11, 59, 50, 0);
        check_time("noon.load", 11, 59, 50, 0);
        repeat (9) tick();
        check_time("noon.e9", 11, 59, 59, 0);
        tick();
        check_time("noon.e10", 12, 0, 0, 1);

        // 12 -> 1 with no AM/PM toggle.
        load_time_now(12, 59, 58, 1);
        repeat (2) tick();
        check_time("h12to1", 1, 0, 0, 1);

        // Midnight rollover.
        load_time_now(11, 59, 30, 1);
        repeat (30) tick();
        check_time("midnight", 12, 0, 0, 0);

        // Out-of-range hour 0 advances to 1.
        load_time_now(0, 59, 59, 0);
        tick();
        check_time("h0to1", 1, 0, 0, 0);

        // Alarm fire at 1:00 PM.
        alarm_en = 1'b1;
        set_alarm(1, 0, 1);
        load_alm = 1'b1;
        load_time_now(12, 59, 50, 1);
        load_alm = 1'b0;
        check("fire.before", int'(alarm), 0);
        repeat (10) tick();
        check_time("fire.at", 1, 0, 0, 1);
        check("fire.on", int'(alarm), 1);
        for (int i = 1; i < 60; i++) begin
            tick();
            check("fire.hold", int'(alarm), 1);
        end
        check_time("fire.last", 1, 0, 59, 1);
        tick();
        check_time("fire.end", 1, 1, 0, 1);
        check("fire.off", int'(alarm), 0);

        // Same sequence with alarm at 1:00 AM: never fires.
        set_alarm(1, 0, 0);
        load_alm = 1'b1;
        load_time_now(12, 59, 50, 1);
        load_alm = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            check("am.nofire", int'(alarm), 0);
        end
        check_time("am.end", 1, 1, 0, 1);

        // Enable gating and alarm reload during an active alarm.
        set_alarm(1, 0, 1);
        load_alm = 1'b1;
        load_time_now(1, 0, 10, 1);
        load_alm = 1'b0;
        check("en.active", int'(alarm), 1);
        alarm_en = 1'b0;
        #1;
        check("en.drop", int'(alarm), 0);
        alarm_en = 1'b1;
        #1;
        check("en.restore", int'(alarm), 1);
        set_alarm(11, 0, 0);
        load_alm = 1'b1;
        tick();
        load_alm = 1'b0;
        check("reload.off", int'(alarm), 0);

        // Held LoadTime keeps the time frozen.
        set_time(9, 57, 0, 0);
        load_time = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_time("hold", 9, 57, 0, 0);
        end
        load_time = 1'b0;

        // Simultaneous time and alarm load with matching minute.
        check("both.before", int'(alarm), 0);
        set_time(9, 57, 30, 0);
        set_alarm(9, 57, 0);
        load_time = 1'b1;
        load_alm  = 1'b1;
        tick();
        load_time = 1'b0;
        load_alm  = 1'b0;
        check_time("both.time", 9, 57, 30, 0);
        check("both.alarm", int'(alarm), 1);
        tick();
        check_time("both.count", 9, 57, 31, 0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check_time("areset", 12, 0, 0, 0);
        check("areset.alarm", int'(alarm), 1);
        rst = 1'b0;
        tick();
        check_time("areset.resume", 12, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
